// File: rtl/bus_master_if_if.sv
`default_nettype none
// ============================================================================
//  Module   : bus_master_if_if
//  Brief    : Core command, bus handshake and response bundle for bus_master_if.
//  Revision : 1.0 - initial release
// ============================================================================
interface bus_master_if_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              busreq;
    logic              grant;
    logic              read_write;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              ready;
    logic [1:0]        response;
    logic              split;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  grant, m_rdata, ready, response, split,
        output cmd_ready, busreq, read_write, m_addr, m_wdata,
        output rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output grant, m_rdata, ready, response, split,
        input  cmd_ready, busreq, read_write, m_addr, m_wdata,
        input  rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/bus_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : bus_master_if
//  Brief    : Single-command bus master front end (request/grant, retry, split).
//             Optional XFER watchdog enabled by defining TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module bus_master_if #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int MAX_RETRY = 3
`ifdef TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 15
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_master_if_if.master      bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_SPLIT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] RSP_OKAY  = 2'b00;
    localparam logic [1:0] RSP_ERROR = 2'b01;
    localparam logic [1:0] RSP_RETRY = 2'b10;

    localparam int          RW        = $clog2(MAX_RETRY + 2);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    logic [2:0]        state_q, state_d;
    logic              busreq_q, busreq_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              cmd_write_q, cmd_write_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [RW-1:0]     retry_inc;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

`ifdef TIMEOUT_EN
    localparam int            TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0]   to_q, to_d;
`endif

    assign retry_inc = retry_q + RW'(1);

    always_comb begin
        state_d     = state_q;
        busreq_d    = busreq_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        retry_d     = retry_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef TIMEOUT_EN
        to_d        = to_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_write_d = bus.cmd_write;
                    cmd_addr_d  = bus.cmd_addr;
                    cmd_wdata_d = bus.cmd_wdata;
                    retry_d     = '0;
                    busreq_d    = 1'b1;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                // After a retry busreq is low for one cycle; a grant seen then is stale.
                if (!busreq_q) begin
                    busreq_d = 1'b1;
                end else if (bus.grant) begin
                    rw_d    = cmd_write_q;
                    addr_d  = cmd_addr_q;
                    wdata_d = cmd_wdata_q;
                    state_d = S_XFER;
`ifdef TIMEOUT_EN
                    to_d    = '0;
`endif
                end
            end
            S_XFER: begin
                if (bus.ready) begin
                    case (bus.response)
                        RSP_OKAY: begin
                            state_d     = S_DONE;
                            busreq_d    = 1'b0;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b0;
                            rsp_rdata_d = cmd_write_q ? '0 : bus.m_rdata;
                        end
                        RSP_ERROR: begin
                            state_d     = S_DONE;
                            busreq_d    = 1'b0;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                            rsp_rdata_d = '0;
                        end
                        RSP_RETRY: begin
                            retry_d  = retry_inc;
                            busreq_d = 1'b0;
                            if (retry_inc <= RETRY_LIM) begin
                                state_d = S_REQ;
                            end else begin
                                state_d     = S_DONE;
                                rsp_valid_d = 1'b1;
                                rsp_err_d   = 1'b1;
                                rsp_rdata_d = '0;
                            end
                        end
                        default: begin
                            state_d  = S_SPLIT;
                            busreq_d = 1'b0;
                        end
                    endcase
                end else begin
`ifdef TIMEOUT_EN
                    to_d = to_q + TO_W'(1);
                    if (to_q == TO_LAST) begin
                        state_d     = S_DONE;
                        busreq_d    = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else
`endif
                    if (!bus.grant) begin
                        state_d = S_REQ;
                    end
                end
            end
            S_SPLIT: begin
                busreq_d = 1'b0;
                if (!bus.split) begin
                    busreq_d = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                busreq_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busreq_q    <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            retry_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef TIMEOUT_EN
            to_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            busreq_q    <= busreq_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            retry_q     <= retry_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef TIMEOUT_EN
            to_q        <= to_d;
`endif
        end
    end

    assign bus.cmd_ready  = (state_q == S_IDLE);
    assign bus.busreq     = busreq_q;
    assign bus.read_write = rw_q;
    assign bus.m_addr     = addr_q;
    assign bus.m_wdata    = wdata_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_master_if
//  Brief    : Directed vector table plus retry/split/grant-loss/reset/timeout sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_master_if;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bus_master_if_if #(.ADDR_W(12), .DATA_W(8)) bus ();

    bus_master_if #(.ADDR_W(12), .DATA_W(8), .MAX_RETRY(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        wr;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic [1:0]  resp;
        logic [7:0]  rdata;
        logic        exp_err;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs [0:5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.grant     = 1'b0;
        bus.m_rdata   = '0;
        bus.ready     = 1'b0;
        bus.response  = 2'b00;
        bus.split     = 1'b0;
    endtask

    // Presents a command for one edge; returns at the negedge after acceptance.
    task automatic issue(input logic wr, input logic [11:0] a, input logic [7:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int  lows;
        int  hit;
        logic seen;

        vecs[0] = '{wr:1'b1, addr:12'h0A5, wdata:8'h3C, resp:2'b00, rdata:8'hEE, exp_err:1'b0, exp_rdata:8'h00};
        vecs[1] = '{wr:1'b0, addr:12'h010, wdata:8'h00, resp:2'b00, rdata:8'h5A, exp_err:1'b0, exp_rdata:8'h5A};
        vecs[2] = '{wr:1'b0, addr:12'h3F0, wdata:8'h11, resp:2'b01, rdata:8'h99, exp_err:1'b1, exp_rdata:8'h00};
        vecs[3] = '{wr:1'b1, addr:12'hFFF, wdata:8'hFF, resp:2'b01, rdata:8'h42, exp_err:1'b1, exp_rdata:8'h00};
        vecs[4] = '{wr:1'b0, addr:12'h000, wdata:8'hA5, resp:2'b00, rdata:8'hFF, exp_err:1'b0, exp_rdata:8'hFF};
        vecs[5] = '{wr:1'b0, addr:12'h800, wdata:8'h00, resp:2'b00, rdata:8'h00, exp_err:1'b0, exp_rdata:8'h00};

        idle_inputs();
        do_reset();
        step();

        check("rst_busreq",     {31'd0, bus.busreq},     32'd0);
        check("rst_cmd_ready",  {31'd0, bus.cmd_ready},  32'd1);
        check("rst_rsp_valid",  {31'd0, bus.rsp_valid},  32'd0);
        check("rst_rsp_err",    {31'd0, bus.rsp_err},    32'd0);
        check("rst_rsp_rdata",  {24'd0, bus.rsp_rdata},  32'd0);
        check("rst_read_write", {31'd0, bus.read_write}, 32'd0);
        check("rst_m_addr",     {20'd0, bus.m_addr},     32'd0);
        check("rst_m_wdata",    {24'd0, bus.m_wdata},    32'd0);

        // Minimum-latency single transfers: accept at N, XFER at N+2, rsp_valid seen at N+3.
        for (int i = 0; i < 6; i++) begin
            bus.grant    = 1'b1;
            bus.ready    = 1'b1;
            bus.response = vecs[i].resp;
            bus.m_rdata  = vecs[i].rdata;
            issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            check($sformatf("v%0d_busreq_n1", i),   {31'd0, bus.busreq},    32'd1);
            check($sformatf("v%0d_cmdrdy_n1", i),   {31'd0, bus.cmd_ready}, 32'd0);
            step();
            check($sformatf("v%0d_rw", i),          {31'd0, bus.read_write}, {31'd0, vecs[i].wr});
            check($sformatf("v%0d_addr", i),        {20'd0, bus.m_addr},     {20'd0, vecs[i].addr});
            check($sformatf("v%0d_wdata", i),       {24'd0, bus.m_wdata},    {24'd0, vecs[i].wdata});
            check($sformatf("v%0d_valid_n2", i),    {31'd0, bus.rsp_valid},  32'd0);
            step();
            check($sformatf("v%0d_valid_n3", i),    {31'd0, bus.rsp_valid},  32'd1);
            check($sformatf("v%0d_err", i),         {31'd0, bus.rsp_err},    {31'd0, vecs[i].exp_err});
            check($sformatf("v%0d_rdata", i),       {24'd0, bus.rsp_rdata},  {24'd0, vecs[i].exp_rdata});
            check($sformatf("v%0d_busreq_done", i), {31'd0, bus.busreq},     32'd0);
            idle_inputs();
            step();
            check($sformatf("v%0d_valid_pulse", i), {31'd0, bus.rsp_valid},  32'd0);
            check($sformatf("v%0d_cmdrdy_back", i), {31'd0, bus.cmd_ready},  32'd1);
            check($sformatf("v%0d_err_hold", i),    {31'd0, bus.rsp_err},    {31'd0, vecs[i].exp_err});
        end

        // RETRY on every attempt: three one-cycle busreq drops, error on the 4th.
        bus.grant    = 1'b1;
        bus.ready    = 1'b1;
        bus.response = 2'b10;
        bus.m_rdata  = 8'h77;
        issue(1'b0, 12'h123, 8'h00);
        lows = 0;
        hit  = 0;
        for (int k = 1; k <= 40 && hit == 0; k++) begin
            step();
            if (bus.rsp_valid) hit = k;
            else if (!bus.busreq) lows++;
        end
        check("retry_latency", hit, 11);
        check("retry_lows",    lows, 3);
        check("retry_err",     {31'd0, bus.rsp_err},   32'd1);
        check("retry_rdata",   {24'd0, bus.rsp_rdata}, 32'd0);
        idle_inputs();
        step();

        // SPLIT: busreq stays low while split is held; a stray command is ignored.
        bus.grant    = 1'b1;
        bus.ready    = 1'b1;
        bus.response = 2'b11;
        bus.split    = 1'b1;
        issue(1'b1, 12'h200, 8'h77);
        step();
        step();
        bus.ready = 1'b0;
        check("split_enter_busreq", {31'd0, bus.busreq}, 32'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 12'h555;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("split_wait%0d_busreq", k), {31'd0, bus.busreq},    32'd0);
            check($sformatf("split_wait%0d_valid", k),  {31'd0, bus.rsp_valid}, 32'd0);
        end
        bus.cmd_valid = 1'b0;
        bus.split     = 1'b0;
        bus.ready     = 1'b1;
        bus.response  = 2'b00;
        step();
        check("split_rereq_busreq", {31'd0, bus.busreq}, 32'd1);
        step();
        check("split_addr", {20'd0, bus.m_addr},  32'h200);
        check("split_wdata", {24'd0, bus.m_wdata}, 32'h77);
        step();
        check("split_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("split_err",   {31'd0, bus.rsp_err},   32'd0);
        idle_inputs();
        step();
        check("split_no_extra", {31'd0, bus.rsp_valid}, 32'd0);
        check("split_idle",     {31'd0, bus.cmd_ready}, 32'd1);

        // Grant loss without ready re-requests; ready wins when grant falls with it.
        bus.grant = 1'b1;
        issue(1'b0, 12'h0F0, 8'h00);
        step();
        bus.grant = 1'b0;
        step();
        check("gloss_busreq", {31'd0, bus.busreq},    32'd1);
        check("gloss_valid",  {31'd0, bus.rsp_valid}, 32'd0);
        bus.grant = 1'b1;
        step();
        bus.grant    = 1'b0;
        bus.ready    = 1'b1;
        bus.response = 2'b00;
        bus.m_rdata  = 8'hA7;
        step();
        check("gloss_valid2", {31'd0, bus.rsp_valid}, 32'd1);
        check("gloss_rdata",  {24'd0, bus.rsp_rdata}, 32'hA7);
        check("gloss_err",    {31'd0, bus.rsp_err},   32'd0);
        idle_inputs();
        step();

        // Reset while in XFER: abort silently.
        bus.grant = 1'b1;
        issue(1'b1, 12'h321, 8'h12);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.grant = 1'b0;
        check("rstx_busreq",    {31'd0, bus.busreq},    32'd0);
        check("rstx_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            seen = seen | bus.rsp_valid;
            step();
        end
        check("rstx_no_valid", {31'd0, seen}, 32'd0);

        // XFER with grant held and ready low.
        bus.grant = 1'b1;
        issue(1'b0, 12'h0AA, 8'h00);
        hit = 0;
`ifdef TIMEOUT_EN
        for (int k = 1; k <= 40 && hit == 0; k++) begin
            step();
            if (bus.rsp_valid) hit = k;
        end
        check("timeout_latency", hit, 16);
        check("timeout_err",     {31'd0, bus.rsp_err}, 32'd1);
        check("timeout_busreq",  {31'd0, bus.busreq},  32'd0);
`else
        for (int k = 1; k <= 100; k++) begin
            step();
            if (bus.rsp_valid && hit == 0) hit = k;
        end
        check("notimeout_valid",  hit, 0);
        check("notimeout_busreq", {31'd0, bus.busreq},    32'd1);
        check("notimeout_ready",  {31'd0, bus.cmd_ready}, 32'd0);
`endif
        idle_inputs();
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
